// File: rtl/bcd_pkg.sv
// ============================================================================
// Module : bcd_pkg
// Shared constants and state encoding for the digit-serial BCD adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package bcd_pkg;
  localparam int BCD_W    = 4;
  localparam int BCD_MAX  = 9;
  localparam int BCD_CORR = 6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;
endpackage

`default_nettype wire

// File: rtl/bcd_digit_add.sv
// ============================================================================
// Module : bcd_digit_add
// Combinational single-digit decimal adder with carry in/out.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] x,
  input  logic [BCD_W-1:0] y,
  input  logic             ci,
  output logic [BCD_W-1:0] s,
  output logic             co
);

  logic [BCD_W:0] w_t;

  always_comb begin
    w_t = {1'b0, x} + {1'b0, y} + {{BCD_W{1'b0}}, ci};
    co  = (w_t > (BCD_W+1)'(BCD_MAX));
    // Correction is applied modulo 16, so it holds for non-BCD digits too.
    s   = co ? (w_t[BCD_W-1:0] + BCD_W'(BCD_CORR)) : w_t[BCD_W-1:0];
  end

endmodule

`default_nettype wire

// File: rtl/bcd_serial_add_ctrl.sv
// ============================================================================
// Module : bcd_serial_add_ctrl
// Digit-serial packed-BCD adder sequencer driving one shared digit adder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [BCD_W*DIGITS-1:0] a,
  input  logic [BCD_W*DIGITS-1:0] b,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [BCD_W*DIGITS-1:0] sum,
  output logic                    cout,
  output logic                    err
);

  localparam int            W    = BCD_W * DIGITS;
  localparam int            CW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  opa_q, opa_d, opb_q, opb_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          errp_q, errp_d;
  logic          cout_q, cout_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic [BCD_W-1:0] w_s;
  logic             w_co;
  logic             w_in_bad;
  logic [W-1:0]     w_acc_shift;

  bcd_digit_add u_add (
    .x  (opa_q[BCD_W-1:0]),
    .y  (opb_q[BCD_W-1:0]),
    .ci (carry_q),
    .s  (w_s),
    .co (w_co)
  );

  always_comb begin
    w_in_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[BCD_W*i +: BCD_W] > BCD_W'(BCD_MAX)) w_in_bad = 1'b1;
      if (b[BCD_W*i +: BCD_W] > BCD_W'(BCD_MAX)) w_in_bad = 1'b1;
    end
  end

  // New digit enters at the top; after DIGITS shifts digit 0 sits at the bottom.
  assign w_acc_shift = (acc_q >> BCD_W) | (W'(w_s) << (W - BCD_W));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    errp_d  = errp_q;
    cout_d  = cout_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          opa_d   = a;
          opb_d   = b;
          carry_d = cin;
          acc_d   = '0;
          errp_d  = w_in_bad;
        end
      end
      ST_RUN: begin
        opa_d   = opa_q >> BCD_W;
        opb_d   = opb_q >> BCD_W;
        carry_d = w_co;
        acc_d   = w_acc_shift;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sum_d   = w_acc_shift;
          cout_d  = w_co;
          err_d   = errp_q;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      errp_q  <= 1'b0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      errp_q  <= errp_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_add_ctrl.sv
// ============================================================================
// Module : tb_bcd_serial_add_ctrl
// Directed and random checks of the serial BCD adder against a decimal model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bcd_serial_add_ctrl;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done, cout, err;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_sum, prev_sum;
  logic         exp_cout, prev_cout, exp_err, prev_err;

  bcd_serial_add_ctrl #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Valid operands use plain decimal arithmetic; any non-BCD digit falls back
  // to the digit-by-digit rule so the result is still predictable.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       output logic [W-1:0] s, output logic co, output logic e);
    longint vx = 0, vy = 0, tot, lim = 1, r;
    int t, cc;
    e = 1'b0;
    for (int i = 0; i < D; i++)
      if (x[4*i +: 4] > 9 || y[4*i +: 4] > 9) e = 1'b1;
    s = '0;
    if (!e) begin
      for (int i = D - 1; i >= 0; i--) begin
        vx = vx * 10 + longint'(x[4*i +: 4]);
        vy = vy * 10 + longint'(y[4*i +: 4]);
        lim = lim * 10;
      end
      tot = vx + vy + longint'(c);
      co  = (tot >= lim);
      r   = tot % lim;
      for (int i = 0; i < D; i++) begin
        s[4*i +: 4] = 4'(r % 10);
        r = r / 10;
      end
    end else begin
      cc = int'(c);
      for (int i = 0; i < D; i++) begin
        t  = int'(x[4*i +: 4]) + int'(y[4*i +: 4]) + cc;
        cc = (t > 9) ? 1 : 0;
        s[4*i +: 4] = (t > 9) ? 4'((t + 6) % 16) : 4'(t);
      end
      co = (cc == 1);
    end
  endtask

  // Called at a negedge: drives start for one edge, returns at the negedge after capture.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    model(x, y, c, exp_sum, exp_cout, exp_err);
    a = x; b = y; cin = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  // Waits for done; optionally pokes start with other operands mid-run.
  task automatic wait_done(input bit interfere);
    int n = 0, bcnt = 0;
    chk("busy_after_capture", 64'(busy), 64'd1);
    while (!done && n < 50) begin
      if (busy) bcnt++;
      chk("held_sum", 64'(sum), 64'(prev_sum));
      if (n == 0) chk("held_cout_err", {62'd0, cout, err}, {62'd0, prev_cout, prev_err});
      if (interfere && n == 1) begin
        start = 1'b1; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      end
      if (n == 2) start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk("done_latency", 64'(n), 64'(D));
    chk("busy_cycles", 64'(bcnt), 64'(D));
    chk("busy_in_done", 64'(busy), 64'd0);
    chk("sum", 64'(sum), 64'(exp_sum));
    chk("cout", 64'(cout), 64'(exp_cout));
    chk("err", 64'(err), 64'(exp_err));
    prev_sum = exp_sum; prev_cout = exp_cout; prev_err = exp_err;
  endtask

  task automatic pulse_end;
    @(negedge clk);
    chk("done_single_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    logic [W-1:0] rx, ry;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    prev_sum = '0; prev_cout = 1'b0; prev_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", {44'd0, busy, done, sum, cout, err}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    launch(16'h1234, 16'h5678, 1'b0); wait_done(0); pulse_end();
    chk("dir_6912", 64'(sum), 64'h6912);
    launch(16'h9999, 16'h0001, 1'b0); wait_done(0); pulse_end();
    chk("dir_ripple_cout", {47'd0, cout, sum}, {47'd0, 1'b1, 16'h0000});
    launch(16'h0789, 16'h0211, 1'b1); wait_done(0); pulse_end();
    chk("dir_1001", 64'(sum), 64'h1001);
    launch(16'h9999, 16'h9999, 1'b1); wait_done(0); pulse_end();
    chk("dir_max", {47'd0, cout, sum}, {47'd0, 1'b1, 16'h9999});
    launch(16'h00A0, 16'h0005, 1'b0); wait_done(0); pulse_end();
    chk("dir_err", {46'd0, err, cout, sum}, {46'd0, 1'b1, 1'b0, 16'h0105});
    launch(16'h0011, 16'h0022, 1'b0); wait_done(0); pulse_end();
    chk("dir_err_clear", 64'(err), 64'd0);

    // Start while busy is ignored; start in the done cycle chains the next add.
    launch(16'h4321, 16'h1111, 1'b0); wait_done(1);
    launch(16'h0505, 16'h0505, 1'b1); wait_done(0); pulse_end();

    // Abort on the second RUN edge.
    launch(16'h2468, 16'h1357, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_outputs", {44'd0, busy, done, sum, cout, err}, 64'd0);
    for (int i = 0; i < D + 2; i++) begin
      chk("abort_no_done", 64'(done), 64'd0);
      @(negedge clk);
    end
    prev_sum = '0; prev_cout = 1'b0; prev_err = 1'b0;
    launch(16'h2468, 16'h1357, 1'b0); wait_done(0); pulse_end();

    for (int k = 0; k < 24; k++) begin
      for (int i = 0; i < D; i++) begin
        rx[4*i +: 4] = (k % 6 == 5) ? 4'($urandom_range(15, 0)) : 4'($urandom_range(9, 0));
        ry[4*i +: 4] = 4'($urandom_range(9, 0));
      end
      launch(rx, ry, 1'($urandom));
      wait_done(k % 4 == 1);
      if (k % 3 == 0) pulse_end();
    end
    pulse_end();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
